// File: rtl/alu_pkg.sv
// alu_pkg: op encoding and FSM states shared by the serial ALU files
package alu_pkg;
  typedef enum logic [1:0] {OP_NOR = 2'b00, OP_XOR = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11} op_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: one-bit NOR/XOR/ADD/SUB cell; SUB adds the inverted b with the carry preset to 1
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  op_t  op,
  output logic s,
  output logic cout
);
  logic bb;
  always_comb begin
    bb = (op == OP_SUB) ? ~b : b;
    s = (op == OP_NOR) ? ~(a | b) : (op == OP_XOR) ? (a ^ b) : (a ^ bb ^ cin);
    cout = (a & bb) | (a & cin) | (bb & cin);
  end
endmodule

// File: rtl/alu_serial.sv
// alu_serial: bit-serial ALU, one result bit per clock LSB first, through a single shared bit slice
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, next;
  op_t rop;
  logic [WIDTH-1:0] ra, rb, acc, fin;
  logic [CW-1:0] cnt;
  logic c, s, co, last, arith;
  assign last = cnt == LAST;
  assign arith = rop[1];
  assign fin = {s, acc[WIDTH-1:1]};
  // operands shift right so bit [cnt] of the captured value is always at position 0
  alu_bit_slice u_slice (.a(ra[0]), .b(rb[0]), .cin(c), .op(rop), .s(s), .cout(co));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb
    next = (state == BUSY) ? (last ? DONE : BUSY) : (start ? BUSY : IDLE);
  always_comb begin
    ready = state != BUSY;
    busy = state == BUSY;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ra <= '0;
      rb <= '0;
      acc <= '0;
      rop <= OP_NOR;
      cnt <= '0;
      c <= 1'b0;
      result <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
      zero <= 1'b0;
    end else if (start && ready) begin
      ra <= a;
      rb <= b;
      rop <= op_t'(op);
      cnt <= '0;
      c <= op_t'(op) == OP_SUB;
    end else if (busy) begin
      ra <= ra >> 1;
      rb <= rb >> 1;
      acc <= fin;
      c <= co;
      cnt <= last ? cnt : cnt + 1'b1;
      if (last) begin
        result <= fin;
        cout <= arith & co;
        ovf <= arith & (c ^ co);
        zero <= fin == '0;
      end
    end
endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: directed vectors for the 8-bit serial ALU, checked by a done-driven scoreboard
module tb_alu_serial;
  import alu_pkg::*;
  logic clk = 1'b0, rst, start;
  logic [1:0] op;
  logic [7:0] a, b, result;
  logic ready, busy, done, cout, ovf, zero;
  int errors = 0, checks = 0;
  typedef struct {
    logic [7:0] r;
    logic c, o, z;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;
  logic [7:0] prev = 8'h00;

  alu_serial #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .result(result),
    .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, want, $time);
    end
  endtask

  always @(negedge clk)
    if (!rst && done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        m_e = sb.pop_front();
        chk("result", result, m_e.r);
        chk("cout", cout, m_e.c);
        chk("ovf", ovf, m_e.o);
        chk("zero", zero, m_e.z);
      end
    end

  task automatic wait_done(output int k);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] r, input logic co, input logic ov, input logic z);
    int k;
    @(negedge clk);
    a = x; b = y; op = o; start = 1'b1;
    sb.push_back('{r, co, ov, z});
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_accept", busy, 1);
    wait_done(k);
    chk("latency", k, 8);
    chk("ready_in_done", ready, 1);
    prev = r;
  endtask

  initial begin
    int k, n;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {cout, ovf, zero}, 0);
    @(negedge clk) rst = 1'b0;

    run(OP_ADD, 8'hFF, 8'h01, 8'h00, 1, 0, 1);
    @(posedge clk);
    #1 chk("done_one_cycle", done, 0);
    run(OP_SUB, 8'h80, 8'h01, 8'h7F, 1, 1, 0);
    run(OP_SUB, 8'h00, 8'h01, 8'hFF, 0, 0, 0);
    run(OP_NOR, 8'h0F, 8'h33, 8'hC0, 0, 0, 0);
    run(OP_XOR, 8'hAA, 8'h55, 8'hFF, 0, 0, 0);

    // start during BUSY with fresh operands must be ignored
    @(negedge clk);
    a = 8'h10; b = 8'h20; op = OP_ADD; start = 1'b1;
    sb.push_back('{8'h30, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("result_hold_busy", result, prev);
    a = 8'h55; b = 8'h77; op = OP_SUB; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("still_busy", busy, 1);
    wait_done(k);
    chk("latency_ignored_start", k, 5);
    prev = 8'h30;

    // reset in the middle of an operation
    @(negedge clk);
    a = 8'h7F; b = 8'h01; op = OP_ADD; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_result", result, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_flags", {cout, ovf, zero, done}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    n = 0;
    repeat (12) begin
      @(posedge clk);
      #1 n += int'(done);
    end
    chk("no_done_after_rst", n, 0);
    run(OP_ADD, 8'h01, 8'h01, 8'h02, 0, 0, 0);

    // back-to-back: start held high through DONE
    @(negedge clk);
    a = 8'h03; b = 8'h04; op = OP_ADD; start = 1'b1;
    sb.push_back('{8'h07, 1'b0, 1'b0, 1'b0});
    sb.push_back('{8'hFF, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1 a = 8'hF0; b = 8'h0F; op = OP_XOR;
    wait_done(k);
    chk("b2b_first_latency", k, 8);
    @(posedge clk);
    #1;
    chk("b2b_done_pulse", done, 0);
    chk("b2b_busy", busy, 1);
    start = 1'b0;
    wait_done(k);
    chk("b2b_gap", 1 + k, 9);

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
